// File: rtl/dotnos_scan_ctrl.sv
// Raster sequencer for the store-line number column: walks LABELS two-digit labels,
// addresses the digit-glyph ROM and streams one pixel per accepted beat.
module dotnos_scan_ctrl #(
    parameter int LABELS   = 32,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       hl_en,
    input  logic [6:0] hl_line,
    output logic [3:0] rom_x,
    output logic [3:0] rom_y,
    output logic [3:0] rom_no,
    input  logic       rom_pixel,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_data,
    output logic       pix_eol,
    output logic       pix_eof,
    output logic       busy
);

    localparam int             RW       = 11;
    localparam logic [RW-1:0]  LAST_ROW = RW'(LABELS * 16 - 1);
    localparam logic [6:0]     LABELS7  = 7'(LABELS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state, state_nx;
    logic [RW-1:0] r;
    logic [4:0]    c;
    logic [3:0]    tens, ones;
    logic          hl_on_q;
    logic [6:0]    hl_line_q;
    logic          hl_on, hl_match, blank, pixel, load, last_pix;
    logic [6:0]    hl_sel;

    assign rom_x  = c[3:0];
    assign rom_y  = r[3:0];
    assign rom_no = c[4] ? ones : tens;

    // The first pixel is loaded on the accepting edge itself, so the live
    // highlight inputs apply until they are latched.
    assign hl_on    = (state == S_IDLE) ? (hl_en && (hl_line < LABELS7)) : hl_on_q;
    assign hl_sel   = (state == S_IDLE) ? hl_line : hl_line_q;
    assign hl_match = hl_on && (r[RW-1:4] == hl_sel);
    assign blank    = BLANK_LZ && !c[4] && (tens == 4'd0);
    assign pixel    = (rom_pixel && !blank) ^ hl_match;
    assign last_pix = (r == LAST_ROW) && (c == 5'd31);
    assign load     = (state == S_RUN) && (!pix_valid || pix_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (frame_start) state_nx = S_RUN;
            S_RUN:   if (load && last_pix) state_nx = S_DRAIN;
            S_DRAIN: if (pix_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Counters sit at zero whenever the sequencer is idle, so the ROM is
    // already presenting pixel (0,0) when a frame request arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r         <= '0;
            c         <= '0;
            tens      <= '0;
            ones      <= '0;
            hl_on_q   <= 1'b0;
            hl_line_q <= '0;
            pix_valid <= 1'b0;
            pix_data  <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        hl_on_q   <= hl_on;
                        hl_line_q <= hl_line;
                        pix_valid <= 1'b1;
                        pix_data  <= pixel;
                        pix_eol   <= 1'b0;
                        pix_eof   <= 1'b0;
                        r         <= '0;
                        c         <= 5'd1;
                        tens      <= '0;
                        ones      <= '0;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        pix_valid <= 1'b1;
                        pix_data  <= pixel;
                        pix_eol   <= (c == 5'd31);
                        pix_eof   <= last_pix;
                        if (last_pix) begin
                            r    <= '0;
                            c    <= '0;
                            tens <= '0;
                            ones <= '0;
                        end else begin
                            c <= c + 5'd1;
                            if (c == 5'd31) begin
                                r <= r + RW'(1);
                                if (r[3:0] == 4'd15) begin
                                    if (ones == 4'd9) begin
                                        ones <= 4'd0;
                                        tens <= tens + 4'd1;
                                    end else begin
                                        ones <= ones + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                    end
                end
                default: begin
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dotnos_scan_ctrl.sv
// Self-checking bench for dotnos_scan_ctrl: frame scenarios from a table, each beat
// compared with an arithmetic raster model; a second instance runs with BLANK_LZ=0.
module tb_dotnos_scan_ctrl;

    localparam int LABELS = 32;
    localparam int TOTAL  = LABELS * 512;

    logic       clk = 1'b0;
    logic       reset, frame_start, hl_en, pix_ready;
    logic [6:0] hl_line;
    logic [3:0] rom_x, rom_y, rom_no, rom_x0, rom_y0, rom_no0;
    logic       rom_pixel, rom_pixel0;
    logic       pix_valid, pix_data, pix_eol, pix_eof, busy;
    logic       pix_valid0, pix_data0, pix_eol0, pix_eof0, busy0;

    int checks = 0;
    int errors = 0;

    assign rom_pixel  = rom_x[0] ^ rom_y[0] ^ rom_no[0];
    assign rom_pixel0 = rom_x0[0] ^ rom_y0[0] ^ rom_no0[0];

    always #5 clk = ~clk;

    dotnos_scan_ctrl #(.LABELS(LABELS), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .hl_en(hl_en), .hl_line(hl_line),
        .rom_x(rom_x), .rom_y(rom_y), .rom_no(rom_no), .rom_pixel(rom_pixel),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );

    dotnos_scan_ctrl #(.LABELS(LABELS), .BLANK_LZ(1'b0)) dut_nolz (
        .clk(clk), .reset(reset), .frame_start(frame_start), .hl_en(hl_en), .hl_line(hl_line),
        .rom_x(rom_x0), .rom_y(rom_y0), .rom_no(rom_no0), .rom_pixel(rom_pixel0),
        .pix_valid(pix_valid0), .pix_ready(pix_ready), .pix_data(pix_data0),
        .pix_eol(pix_eol0), .pix_eof(pix_eof0), .busy(busy0)
    );

    typedef struct {
        bit         hl_en;
        logic [6:0] hl_line;
        bit         rnd;
        bit         mid_change;
        bit         inject;
        int         abort_at;
        int         exp_inv;
    } frame_t;

    frame_t tbl[4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {data, eol, eof} of beat k, from label/row/column arithmetic.
    function automatic logic [2:0] model_beat(input int k, input bit blank, input int inv);
        int row, col, label, tens, ones, no, p;
        row   = k / 32;
        col   = k % 32;
        label = row / 16;
        tens  = label / 10;
        ones  = label % 10;
        no    = (col >= 16) ? ones : tens;
        p     = ((col % 16) ^ (row % 16) ^ no) & 1;
        if (blank && col < 16 && tens == 0) p = 0;
        if (label == inv) p = p ^ 1;
        return {p[0], col == 31, k == TOTAL - 1};
    endfunction

    // Expected {rom_x, rom_y, rom_no} while the sequencer is positioned on beat j.
    function automatic logic [11:0] model_addr(input int j);
        int row, col, label, no;
        if (j >= TOTAL) return 12'h000;
        row   = j / 32;
        col   = j % 32;
        label = row / 16;
        no    = (col >= 16) ? (label % 10) : (label / 10);
        return {4'(col % 16), 4'(row % 16), 4'(no)};
    endfunction

    task automatic applyStimulus(input frame_t f);
        int         h, cyc, eols, eofs;
        bit         pvalid, pready;
        logic [2:0] pv, pv0;
        h = 0; cyc = 0; eols = 0; eofs = 0;
        pvalid = 1'b0; pready = 1'b0; pv = '0; pv0 = '0;
        frame_start = 1'b1;
        hl_en       = f.hl_en;
        hl_line     = f.hl_line;
        @(negedge clk);
        frame_start = 1'b0;
        checkOutput("busy_latency", busy, 1);
        checkOutput("valid_latency", pix_valid, 1);
        while (h < TOTAL && cyc < TOTAL * 4) begin
            if (f.abort_at == h) begin
                reset = 1'b1;
                #1;
                checkOutput("abort_valid", pix_valid, 0);
                checkOutput("abort_valid_nolz", pix_valid0, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_flags", {pix_data, pix_eol, pix_eof}, 0);
                checkOutput("abort_rom", {rom_x, rom_y, rom_no}, 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            checkOutput("valid_held", pix_valid, 1);
            if (pvalid && !pready) begin
                checkOutput("stall_data", {pix_data, pix_eol, pix_eof}, pv);
                checkOutput("stall_data_nolz", {pix_data0, pix_eol0, pix_eof0}, pv0);
            end
            checkOutput("rom_addr", {rom_x, rom_y, rom_no}, model_addr(h + 1));
            pready    = f.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready = pready;
            pvalid    = pix_valid;
            pv        = {pix_data, pix_eol, pix_eof};
            pv0       = {pix_data0, pix_eol0, pix_eof0};
            if (pix_valid && pready) begin
                checkOutput("beat", pv, model_beat(h, 1'b1, f.exp_inv));
                checkOutput("beat_nolz", pv0, model_beat(h, 1'b0, f.exp_inv));
                eols += int'(pix_eol);
                eofs += int'(pix_eof);
                h++;
            end
            if (f.mid_change && h >= 3000) begin
                hl_en   = 1'b0;
                hl_line = 7'd0;
            end
            frame_start = (f.inject && h >= 5000 && h < 5003) ? 1'b1 : 1'b0;
            cyc++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        checkOutput("frame_timeout", h, TOTAL);
        checkOutput("eol_count", eols, LABELS * 16);
        checkOutput("eof_count", eofs, 1);
        if (!f.rnd) checkOutput("frame_cycles", cyc, TOTAL);
        checkOutput("busy_fall", busy, 0);
        checkOutput("busy_fall_nolz", busy0, 0);
        checkOutput("valid_fall", pix_valid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        hl_en       = 1'b0;
        hl_line     = 7'd0;
        pix_ready   = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_flags", {pix_data, pix_eol, pix_eof}, 0);
        checkOutput("rst_rom", {rom_x, rom_y, rom_no}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_valid", pix_valid, 0);
            checkOutput("idle_busy", busy, 0);
        end

        tbl[0] = '{hl_en: 1'b1, hl_line: 7'd7,  rnd: 1'b0, mid_change: 1'b1, inject: 1'b0, abort_at: -1,   exp_inv: 7};
        tbl[1] = '{hl_en: 1'b0, hl_line: 7'd0,  rnd: 1'b0, mid_change: 1'b0, inject: 1'b0, abort_at: 1000, exp_inv: -1};
        tbl[2] = '{hl_en: 1'b1, hl_line: 7'd32, rnd: 1'b0, mid_change: 1'b0, inject: 1'b0, abort_at: -1,   exp_inv: -1};
        tbl[3] = '{hl_en: 1'b1, hl_line: 7'd40, rnd: 1'b1, mid_change: 1'b0, inject: 1'b1, abort_at: -1,   exp_inv: -1};

        for (int i = 0; i < 4; i++) begin
            $display("[TB] frame %0d hl_en=%0d hl_line=%0d", i, tbl[i].hl_en, tbl[i].hl_line);
            applyStimulus(tbl[i]);
        end

        repeat (3) begin
            @(negedge clk);
            checkOutput("post_idle_valid", pix_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
